// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus responder: address map, CLR bit
// positions and the STATUS register layout.
package dbus_pkg;

    // MMIO registers; the 0x060-0x06F window shadows the RAM beneath it.
    localparam logic [31:0] OUTQ_ADR   = 32'h0000_0060;
    localparam logic [31:0] RESULT_ADR = 32'h0000_0064;
    localparam logic [31:0] STATUS_ADR = 32'h0000_0068;
    localparam logic [31:0] CLR_ADR    = 32'h0000_006C;
    // First byte address past the RAM region.
    localparam logic [31:0] RAM_LIMIT  = 32'h0000_0100;

    // Bit positions within a word stored to CLR.
    localparam int CLR_DONE_BIT     = 0;
    localparam int CLR_ERROR_BIT    = 1;
    localparam int CLR_OVERFLOW_BIT = 2;
    localparam int CLR_FLUSH_BIT    = 3;

    // STATUS register as seen by a load of STATUS_ADR.
    typedef struct packed {
        logic [25:0] rsvd;
        logic        overflow;
        logic        error;
        logic        done;
        logic [2:0]  count;
    } status_t;

    // True when the address falls inside the 16-byte MMIO window.
    function automatic logic in_mmio(input logic [31:0] adr);
        return adr[31:4] == OUTQ_ADR[31:4];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with asynchronous reset, synchronous flush and a
// zero-valued head word while empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_en;
    logic          pop_en;

    // A pop needs data; a push into a full FIFO only fits if the head leaves the same edge.
    always_comb begin
        pop_en  = pop && !empty;
        push_en = push && (!full || pop_en);
        full    = count == CW'(DEPTH);
        empty   = count == '0;
        rdata   = empty ? '0 : mem[rd_ptr];
    end

    // Pointers wrap naturally since DEPTH is a power of two; flush wins over traffic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            if (push_en && !pop_en)      count <= count + 1'b1;
            else if (pop_en && !push_en) count <= count - 1'b1;
        end
    end

    // Storage array; no reset needed because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_en && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder for a single-cycle core: word RAM, MMIO registers
// (OUTQ, RESULT, STATUS, CLR) and an output FIFO toward a consumer.
// Output handshake: a word leaves the FIFO on a rising clk edge where
// out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0,
// out_data holds the same head word.
module dbus_responder
    import dbus_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        done,
    output logic [31:0] result
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          mmio_hit;
    logic          ram_hit;
    logic          aligned;
    logic          store_ok;
    logic          wr_ram;
    logic          wr_outq;
    logic          wr_result;
    logic          wr_clr;
    logic          error;
    logic          overflow;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   count_ext;
    status_t       status;

    // Address decode and store qualification.
    always_comb begin
        mmio_hit  = in_mmio(DataAdr);
        ram_hit   = (DataAdr < RAM_LIMIT) && !mmio_hit;
        aligned   = DataAdr[1:0] == 2'b00;
        ram_idx   = DataAdr[AW+1:2];
        store_ok  = MemWrite && aligned && (ram_hit || mmio_hit);
        wr_ram    = store_ok && ram_hit;
        wr_outq   = store_ok && (DataAdr == OUTQ_ADR);
        wr_result = store_ok && (DataAdr == RESULT_ADR);
        wr_clr    = store_ok && (DataAdr == CLR_ADR);
    end

    // Zero-latency load path and STATUS assembly.
    always_comb begin
        count_ext       = 32'(fifo_count);
        status          = '0;
        status.overflow = overflow;
        status.error    = error;
        status.done     = done;
        status.count    = count_ext[2:0];
        ReadData        = '0;
        if (mmio_hit) begin
            case (DataAdr[3:2])
                2'b01:   ReadData = result;
                2'b10:   ReadData = status;
                default: ReadData = '0;
            endcase
        end else if (ram_hit) begin
            ReadData = ram[ram_idx];
        end
    end

    // Data RAM keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wr_ram) ram[ram_idx] <= WriteData;
    end

    // RESULT and sticky flags; a set in the same edge as its clear wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            done     <= 1'b0;
            error    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_result) result <= WriteData;
            done     <= (done && !(wr_clr && WriteData[CLR_DONE_BIT])) || wr_result;
            error    <= (error && !(wr_clr && WriteData[CLR_ERROR_BIT]))
                        || (MemWrite && !store_ok);
            overflow <= (overflow && !(wr_clr && WriteData[CLR_OVERFLOW_BIT]))
                        || (wr_outq && fifo_full && !(out_valid && out_ready));
        end
    end

    assign out_valid = !fifo_empty;

    sync_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (32)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (wr_outq),
        .pop  (out_ready),
        .flush(wr_clr && WriteData[CLR_FLUSH_BIT]),
        .wdata(WriteData),
        .rdata(out_data),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

endmodule

// File: doc/dbus_responder.md
DBUS_RESPONDER -- requirements
Module: dbus_responder

Interface
REQ-001 The block SHALL have parameter RAM_WORDS, default 64: data RAM depth in 32-bit words.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: output FIFO depth, a power of two of at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port MemWrite, input, 1 bit: store strobe from the processor.
REQ-006 The block SHALL have port DataAdr, input, 32 bits: byte address from the processor.
REQ-007 The block SHALL have port WriteData, input, 32 bits: store data from the processor.
REQ-008 The block SHALL have port ReadData, output, 32 bits: load data returned to the processor.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the output FIFO is non-empty.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the head word.
REQ-011 The block SHALL have port out_data, output, 32 bits: the FIFO head word.
REQ-012 The block SHALL have port done, output, 1 bit: a result has been posted.
REQ-013 The block SHALL have port result, output, 32 bits: the last value stored to RESULT.

Function
REQ-014 The address map SHALL be: RAM at 0x000–0x0FF; MMIO window 0x060–0x06F, which overrides RAM; all else unmapped.
REQ-015 The MMIO registers SHALL be: 0x060 OUTQ (write-only push); 0x064 RESULT (read/write); 0x068 STATUS (read-only); 0x06C CLR (write-only).
REQ-016 A store SHALL be accepted only when MemWrite=1, DataAdr[1:0]=00 and the address is mapped; accepted state updates occur on the next rising clk.
REQ-017 A RAM store SHALL write word DataAdr[7:2]; MMIO addresses SHALL never modify RAM.
REQ-018 ReadData SHALL be combinational from DataAdr, with zero latency, as required by a single-cycle core.
REQ-019 ReadData SHALL return: RAM word; RESULT → result; STATUS → {26'b0, overflow, error, done, count[2:0]}; OUTQ, CLR or unmapped → 0.
REQ-020 A store to OUTQ SHALL push WriteData; out_data SHALL show the head word; a pop SHALL occur on a cycle with out_valid=1 and out_ready=1.
REQ-021 count SHALL be 0..FIFO_DEPTH, and the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 A push while full and not popping SHALL be dropped, leaving the FIFO contents unchanged, and SHALL set sticky overflow.
REQ-023 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; count SHALL then be unchanged.
REQ-024 A push and a pop in the same cycle while empty SHALL perform only the push; out_valid is 0, so no pop occurs.
REQ-025 A store to RESULT SHALL load result and set done=1 in the same edge; a later RESULT store SHALL overwrite result, and done SHALL stay 1.
REQ-026 A store to CLR SHALL act per WriteData bit: bit0 clears done, bit1 clears error, bit2 clears overflow, bit3 flushes the FIFO.
REQ-027 A same-edge set and clear of a sticky flag SHALL leave the flag set.
REQ-028 A misaligned or unmapped store SHALL be ignored and SHALL set sticky error.
REQ-029 MemWrite=0 SHALL cause no state change; loads have no side effects.

Reset
REQ-030 Asserting reset SHALL, asynchronously: set the FIFO pointers and count to 0, out_valid=0, out_data=0 (no entry), done=0, result=0, error=0, overflow=0.
REQ-031 RAM contents SHALL NOT be reset.
REQ-032 A reset asserted mid-stream SHALL discard queued FIFO words; the first push after reset release SHALL become the head.

Structure
REQ-033 A shared package dbus_pkg SHALL hold: the address constants (OUTQ_ADR, RESULT_ADR, STATUS_ADR, CLR_ADR, RAM_LIMIT), the CLR bit positions, and a packed status_t typedef.
REQ-034 The FIFO SHALL be one sub-module, sync_fifo, with parameter DEPTH, push/pop/full/empty/count ports, and async reset.
REQ-035 The RAM and the register decode SHALL stay in dbus_responder.

Verification
REQ-036 Directed test: store 7 to 0x64 → next edge done=1, result=7; a load of 0x68 then returns 0x8.
REQ-037 Directed test: out_ready=0, push 1..5 to 0x60 → count=4, overflow=1; out_ready=1 → drain order 1,2,3,4, then out_valid=0.
REQ-038 Directed test: FIFO full, push 9 with out_ready=1 → the head pops, 9 is enqueued, and count stays 4 with no overflow.
REQ-039 Directed test: store 0xDEADBEEF to 0x10, then store to 0x62 and 0x200 → a load of 0x10 returns 0xDEADBEEF, error=1, and RAM is unchanged.
REQ-040 Directed test: 3 words queued, assert reset between clk edges → immediately out_valid=0, done=0; a RAM word written before reset still reads back after release.
REQ-041 Directed test: store 0xF to 0x6C after the error, overflow, done and FIFO data set above → STATUS reads 0 on the next cycle.
